// File: rtl/fix2flt_engine.sv
// Signed 8.8 fixed-point to IEEE-754 binary16 converter with a private byte-wide data memory.
// The operand is read from memory, normalised one bit per cycle, packed, and the result
// bytes are written back before ack rises.
// Optional build macro ROUND_NEAREST_EN: round the mantissa to nearest, ties to even,
// instead of truncating it.

module fix2flt_dmem #(
  parameter int unsigned Depth = 256,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_lo_i,
  input  logic [AddrW-1:0] waddr_hi_i,
  input  logic [7:0]       wdata_lo_i,
  input  logic [7:0]       wdata_hi_i,
  input  logic [AddrW-1:0] raddr_lo_i,
  input  logic [AddrW-1:0] raddr_hi_i,
  output logic [7:0]       rdata_lo_o,
  output logic [7:0]       rdata_hi_o
);

  // No reset: contents survive reset.
  logic [7:0] mem_core [Depth];

  // Both result bytes are written on the same edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_core[waddr_lo_i] <= wdata_lo_i;
      mem_core[waddr_hi_i] <= wdata_hi_i;
    end
  end

  assign rdata_lo_o = mem_core[raddr_lo_i];
  assign rdata_hi_o = mem_core[raddr_hi_i];

endmodule

module fix2flt_engine #(
  parameter int unsigned MEM_DEPTH    = 256,
  parameter int unsigned OPND_LO_ADDR = 0,
  parameter int unsigned OPND_HI_ADDR = 1,
  parameter int unsigned RES_LO_ADDR  = 2,
  parameter int unsigned RES_HI_ADDR  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic ack
);

  localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StNeg   = 3'd2;
  localparam logic [2:0] StNorm  = 3'd3;
  localparam logic [2:0] StPack  = 3'd4;
  localparam logic [2:0] StStore = 3'd5;
  localparam logic [2:0] StDone  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic        start_q;
  logic [15:0] x_q, x_d;
  logic        sign_q, sign_d;
  logic [15:0] mag_q, mag_d;
  logic [3:0]  p_q, p_d;
  logic [15:0] res_q, res_d;

  logic        start_rise;
  logic [7:0]  rdata_lo, rdata_hi;
  logic [14:0] em_trunc, em_final;

  assign start_rise = start & ~start_q;

  fix2flt_dmem #(
    .Depth (MEM_DEPTH),
    .AddrW (AddrW)
  ) dm (
    .clk_i      (clk),
    .we_i       (state_q == StStore),
    .waddr_lo_i (AddrW'(RES_LO_ADDR)),
    .waddr_hi_i (AddrW'(RES_HI_ADDR)),
    .wdata_lo_i (res_q[7:0]),
    .wdata_hi_i (res_q[15:8]),
    .raddr_lo_i (AddrW'(OPND_LO_ADDR)),
    .raddr_hi_i (AddrW'(OPND_HI_ADDR)),
    .rdata_lo_o (rdata_lo),
    .rdata_hi_o (rdata_hi)
  );

  // Exponent and mantissa fields; p_q is the bit position of the leading one.
  assign em_trunc = {5'({1'b0, p_q}) + 5'd7, mag_q[14:5]};

`ifdef ROUND_NEAREST_EN
  logic round_up;
  // Guard bit set and (sticky or odd mantissa); a carry out of the mantissa bumps the exponent.
  assign round_up = mag_q[4] & ((|mag_q[3:0]) | mag_q[5]);
  assign em_final = em_trunc + 15'(round_up);
`else
  logic unused_lsbs;
  assign unused_lsbs = ^mag_q[4:0];
  assign em_final    = em_trunc;
`endif

  // Next-state and datapath sequencing.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    p_d     = p_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (start_rise) state_d = StLoad;
      end
      StLoad: begin
        x_d     = {rdata_hi, rdata_lo};
        sign_d  = rdata_hi[7];
        state_d = StNeg;
      end
      StNeg: begin
        mag_d   = sign_q ? (~x_q + 16'd1) : x_q;
        p_d     = 4'd15;
        state_d = (mag_d == 16'd0) ? StPack : StNorm;
      end
      StNorm: begin
        if (mag_q[15]) begin
          state_d = StPack;
        end else begin
          mag_d = {mag_q[14:0], 1'b0};
          p_d   = p_q - 4'd1;
        end
      end
      StPack: begin
        // Zero never gets a sign bit, so -0.0 cannot be produced.
        res_d   = (mag_q == 16'd0) ? 16'h0000 : {sign_q, em_final};
        state_d = StStore;
      end
      StStore: begin
        state_d = StDone;
      end
      StDone: begin
        if (start_rise) state_d = StLoad;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      x_q     <= 16'd0;
      sign_q  <= 1'b0;
      mag_q   <= 16'd0;
      p_q     <= 4'd0;
      res_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      x_q     <= x_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      p_q     <= p_d;
      res_q   <= res_d;
    end
  end

  // Result bytes are already in memory by the time DONE is entered.
  assign ack = (state_q == StDone);

endmodule

// File: tb/tb_fix2flt_engine.sv
// Self-checking bench for fix2flt_engine: directed table, handshake/reset sequences and
// random operands checked against an arithmetic model of the 8.8 -> binary16 conversion.

module tb_fix2flt_engine;

  localparam int MaxLatency = 22;

  logic clk;
  logic reset;
  logic start;
  logic ack;

  int nvec  = 0;
  int nfail = 0;

  fix2flt_engine dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ack   (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] op;
    logic [15:0] exp_trunc;
    logic [15:0] exp_round;
    int          hold;
    string       name;
  } vec_t;

  vec_t tbl[10];

  // Value-level model: |x|/256 = 1.f * 2^(e-8), biased exponent e-8+15.
  function automatic logic [15:0] model(input logic [15:0] op);
    int v;
    int mag;
    int e;
    int frac;
    int scaled;
    int mant;
    int ex;
    bit s;
    v   = int'($signed(op));
    s   = (v < 0);
    mag = s ? -v : v;
    if (mag == 0) return 16'h0000;
    e = 0;
    while ((1 << (e + 1)) <= mag) e++;
    frac   = mag - (1 << e);
    scaled = frac * 1024;
    mant   = scaled >> e;
    ex     = e + 7;
`ifdef ROUND_NEAREST_EN
    begin
      int rem;
      rem = scaled - (mant << e);
      if ((2 * rem > (1 << e)) || ((2 * rem == (1 << e)) && (mant % 2 == 1))) mant++;
      if (mant == 1024) begin
        mant = 0;
        ex++;
      end
    end
`endif
    return {s, ex[4:0], mant[9:0]};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] result_mem();
    return {dut.dm.mem_core[3], dut.dm.mem_core[2]};
  endfunction

  // One conversion: preload operand, raise start for 'hold' cycles, wait for ack (bounded).
  task automatic convert(input logic [15:0] op, input logic [15:0] expv, input string name,
                         input int hold, input bit scramble);
    int cyc;
    bit seen;
    dut.dm.mem_core[0] = op[7:0];
    dut.dm.mem_core[1] = op[15:8];
    start = 1'b1;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc >= hold) start = 1'b0;
      if (scramble && cyc == 3) begin
        dut.dm.mem_core[0] = 8'($urandom);
        dut.dm.mem_core[1] = 8'($urandom);
      end
      if (cyc == 1) check({name, "_ack_drop"}, {15'd0, ack}, 16'd0);
      else if (ack) seen = 1'b1;
    end
    start = 1'b0;
    nvec++;
    if (!seen || cyc > MaxLatency) begin
      nfail++;
      $display("FAIL %s_latency: ack seen=%0d after %0d cycles, required within %0d",
               name, seen, cyc, MaxLatency);
    end
    check(name, result_mem(), expv);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int okcnt;
    logic [15:0] op;

    tbl[0] = '{16'h0001, 16'h1C00, 16'h1C00, 2, "one_lsb"};
    tbl[1] = '{16'h0003, 16'h2200, 16'h2200, 2, "three_lsb"};
    tbl[2] = '{16'h7FFF, 16'h57FF, 16'h5800, 1, "max_pos"};
    tbl[3] = '{16'h0030, 16'h3200, 16'h3200, 1, "p0_1875"};
    tbl[4] = '{16'h0000, 16'h0000, 16'h0000, 1, "zero"};
    tbl[5] = '{16'hFFFF, 16'h9C00, 16'h9C00, 1, "minus_lsb"};
    tbl[6] = '{16'hFFD0, 16'hB200, 16'hB200, 1, "m0_1875"};
    tbl[7] = '{16'h8000, 16'hD800, 16'hD800, 1, "most_neg"};
    tbl[8] = '{16'hC000, 16'hD400, 16'hD400, 1, "minus_64"};
    tbl[9] = '{16'h0100, 16'h3C00, 16'h3C00, 3, "plus_one"};

    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("reset_ack", {15'd0, ack}, 16'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
`ifdef ROUND_NEAREST_EN
      convert(tbl[i].op, tbl[i].exp_round, tbl[i].name, tbl[i].hold, 1'b0);
`else
      convert(tbl[i].op, tbl[i].exp_trunc, tbl[i].name, tbl[i].hold, 1'b0);
`endif
    end

    // Start held for 5 cycles: one conversion, ack and result stay put afterwards.
    convert(16'h0030, model(16'h0030), "hold5", 5, 1'b0);
    okcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (ack) okcnt++;
    end
    check("ack_held_cycles", 16'(okcnt), 16'd10);
    check("hold5_result_stable", result_mem(), 16'h3200);

    // Next start edge from DONE drops ack and brings a fresh result.
    convert(16'hFFD0, model(16'hFFD0), "from_done", 1, 1'b0);

    // Operand rewritten after LOAD must not affect the result.
    convert(16'h1234, model(16'h1234), "late_write", 1, 1'b1);

    // Reset during NORM aborts: ack low, nothing written, no conversion resumes.
    dut.dm.mem_core[0] = 8'h01;
    dut.dm.mem_core[1] = 8'h00;
    dut.dm.mem_core[2] = 8'hA5;
    dut.dm.mem_core[3] = 8'h5A;
    start = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mid_reset_ack", {15'd0, ack}, 16'd0);
    reset = 1'b1;
    okcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (ack) okcnt++;
    end
    check("post_reset_idle_ack", 16'(okcnt), 16'd0);
    check("post_reset_mem", result_mem(), 16'h5AA5);
    convert(16'hFFFF, model(16'hFFFF), "after_reset", 2, 1'b0);

    // Random operands against the model.
    for (int i = 0; i < 120; i++) begin
      op = 16'($urandom);
      if (i % 8 == 0) op = op >> (i % 15);
      convert(op, model(op), $sformatf("rand%0d_%04h", i, op), 1 + (i % 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
